rv32_exec_mem_wb: RTL and testbench



---
 rtl/rv32_pkg.sv | 49 ++++
 rtl/rv32_dmem.sv | 56 +++++
 rtl/rv32_exec_mem_wb.sv | 230 +++++++++++++++++++++++
 tb/tb_rv32_exec_mem_wb.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: constants shared by the RV32I back end.
//   - major opcodes (OP, OP_IMM, LUI, LOAD, STORE, BRANCH)
//   - funct3 encodings for ALU operations, loads and stores
//   - alu_op_e, the ALU operation selected by the execute stage
package rv32_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Load funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

endpackage

// File: rtl/rv32_dmem.sv
// rv32_dmem: word-organised data RAM with per-byte write enables.
//   Optional build macro: DMEM_RESET_CLEAR_EN -- when defined, rst clears
//   every word asynchronously; otherwise contents survive reset.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   we     in   write enable (sampled at the rising edge)
//   be     in   byte enables, bit i selects byte lane i
//   addr   in   word index shared by the read and write port
//   wdata  in   write data, already placed in its byte lanes
//   rdata  out  combinational read of mem[addr]
module rv32_dmem #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    assign rdata = mem[addr];

`ifdef DMEM_RESET_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end
`else
    // Contents are kept across reset; no write is accepted while it is held.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end
`endif

endmodule

// File: rtl/rv32_exec_mem_wb.sv
// rv32_exec_mem_wb: RV32I back end -- execute (ALU), data-memory access and
// register-file write-back for a single-issue pipeline.
//   Optional build macro: DMEM_RESET_CLEAR_EN (data RAM cleared by rst).
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   ins_dec_out   in   instruction word accompanying the operands
//   alu_in1       in   operand 1 (rs1)
//   alu_in2       in   operand 2 (rs2, or sign-extended immediate)
//   alu_out       out  registered ALU result (store data for stores)
//   zero          out  registered: in1==in2 for branches, else alu_out==0
//   alu_reg_w_en  out  registered: executed instruction writes rd
//   alu_rd        out  registered destination register
//   wb_en         out  register-file write enable
//   wb_reg        out  register-file write address
//   wb_val        out  register-file write data
module rv32_exec_mem_wb
    import rv32_pkg::*;
#(
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ins_dec_out,
    input  logic [31:0] alu_in1,
    input  logic [31:0] alu_in2,
    output logic [31:0] alu_out,
    output logic        zero,
    output logic        alu_reg_w_en,
    output logic [4:0]  alu_rd,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_val
);

    localparam int AW    = $clog2(DMEM_WORDS);
    // Only the byte-address bits that reach the RAM are kept; higher bits wrap.
    localparam int ABITS = AW + 2;

    function automatic alu_op_e alu_decode(input logic [2:0] f3,
                                           input logic       alt,
                                           input logic       is_op);
        case (f3)
            F3_ADD:  return (is_op && alt) ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic [31:0] alu_calc(input alu_op_e            op,
                                             input logic signed [31:0] a,
                                             input logic signed [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return {31'd0, a < b};
            ALU_SLTU: return {31'd0, $unsigned(a) < $unsigned(b)};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return $unsigned(a) >> sh;
            ALU_SRA:  return a >>> sh;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return '0;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0]  f3,
                                             input logic [1:0]  lane,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {lane, 3'b000});
        h = lane[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_LB:   return {{24{b[7]}}, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LBU:  return {24'd0, b};
            F3_LHU:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    // ---- execute (combinational, from the decode-stage inputs) ----
    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [4:0]       rd;
    logic [31:0]      s_imm;
    logic [31:0]      ld_sum;
    logic [31:0]      alu_res;
    logic [31:0]      ex_res;
    logic             ex_zero;
    logic             ex_wen;
    logic             ex_ren;
    logic             ex_sen;
    logic [ABITS-1:0] ex_add;

    assign opcode  = ins_dec_out[6:0];
    assign f3      = ins_dec_out[14:12];
    assign rd      = ins_dec_out[11:7];
    assign s_imm   = {{20{ins_dec_out[31]}}, ins_dec_out[31:25], ins_dec_out[11:7]};
    assign ld_sum  = alu_in1 + alu_in2;
    assign alu_res = alu_calc(alu_decode(f3, ins_dec_out[30], opcode == OP),
                              alu_in1, alu_in2);

    always_comb begin
        ex_res = '0;
        ex_wen = 1'b0;
        ex_ren = 1'b0;
        ex_sen = 1'b0;
        ex_add = '0;
        case (opcode)
            OP, OP_IMM: begin
                ex_res = alu_res;
                ex_wen = 1'b1;
            end
            LUI: begin
                ex_res = {ins_dec_out[31:12], 12'd0};
                ex_wen = 1'b1;
            end
            LOAD: begin
                ex_res = ld_sum;
                ex_add = ABITS'(ld_sum);
                ex_ren = 1'b1;
                ex_wen = 1'b1;
            end
            STORE: begin
                ex_res = alu_in2;
                ex_add = ABITS'(alu_in1 + s_imm);
                ex_sen = 1'b1;
            end
            BRANCH: begin
                ex_res = alu_in1 - alu_in2;
            end
            default: ;
        endcase
        ex_zero = (opcode == BRANCH) ? (alu_in1 == alu_in2) : (ex_res == '0);
        // x0 is hardwired; never request a write to it.
        if (rd == 5'd0) begin
            ex_wen = 1'b0;
        end
    end

    // ---- execute registers (_p1) ----
    logic [2:0]       f3_p1;
    logic             d_r_en_p1;
    logic             d_w_en_p1;
    logic [ABITS-1:0] d_add_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out      <= '0;
            zero         <= 1'b0;
            alu_reg_w_en <= 1'b0;
            alu_rd       <= '0;
            f3_p1        <= '0;
            d_r_en_p1    <= 1'b0;
            d_w_en_p1    <= 1'b0;
            d_add_p1     <= '0;
        end else begin
            alu_out      <= ex_res;
            zero         <= ex_zero;
            alu_reg_w_en <= ex_wen;
            alu_rd       <= rd;
            f3_p1        <= f3;
            d_r_en_p1    <= ex_ren;
            d_w_en_p1    <= ex_sen;
            d_add_p1     <= ex_add;
        end
    end

    // ---- memory access (from execute registers) ----
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [31:0] rd_word;

    // Store data is replicated into every lane so the byte enables alone
    // pick the target bytes.
    always_comb begin
        st_be   = 4'b0000;
        st_data = alu_out;
        case (f3_p1)
            F3_SB: begin
                st_be   = 4'b0001 << d_add_p1[1:0];
                st_data = {4{alu_out[7:0]}};
            end
            F3_SH: begin
                st_be   = d_add_p1[1] ? 4'b1100 : 4'b0011;
                st_data = {2{alu_out[15:0]}};
            end
            F3_SW: begin
                st_be = 4'b1111;
            end
            default: ;
        endcase
    end

    rv32_dmem #(
        .WORDS (DMEM_WORDS)
    ) u_dmem (
        .clk   (clk),
        .rst   (rst),
        .we    (d_w_en_p1),
        .be    (st_be),
        .addr  (d_add_p1[ABITS-1:2]),
        .wdata (st_data),
        .rdata (rd_word)
    );

    // ---- write-back registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en  <= 1'b0;
            wb_reg <= '0;
            wb_val <= '0;
        end else begin
            wb_en  <= alu_reg_w_en;
            wb_reg <= alu_rd;
            wb_val <= d_r_en_p1 ? load_fmt(f3_p1, d_add_p1[1:0], rd_word) : alu_out;
        end
    end

endmodule

// File: tb/tb_rv32_exec_mem_wb.sv
module tb_rv32_exec_mem_wb;

    localparam int WORDS  = 64;
    localparam int NBYTES = 4 * WORDS;

    localparam logic [6:0] C_OP     = 7'h33;
    localparam logic [6:0] C_OPIMM  = 7'h13;
    localparam logic [6:0] C_LUI    = 7'h37;
    localparam logic [6:0] C_LOAD   = 7'h03;
    localparam logic [6:0] C_STORE  = 7'h23;
    localparam logic [6:0] C_BRANCH = 7'h63;
    localparam logic [31:0] BUBBLE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ins_dec_out = '0;
    logic [31:0] alu_in1 = '0;
    logic [31:0] alu_in2 = '0;
    logic [31:0] alu_out;
    logic        zero;
    logic        alu_reg_w_en;
    logic [4:0]  alu_rd;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_val;

    rv32_exec_mem_wb #(.DMEM_WORDS(WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .ins_dec_out  (ins_dec_out),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_out      (alu_out),
        .zero         (zero),
        .alu_reg_w_en (alu_reg_w_en),
        .alu_rd       (alu_rd),
        .wb_en        (wb_en),
        .wb_reg       (wb_reg),
        .wb_val       (wb_val)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] res;
        logic        zero;
        logic        wen;
        logic [4:0]  rd;
        logic        ren;
        logic        sen;
        logic [2:0]  f3;
        logic [31:0] addr;
    } ex_t;

    ex_t         m_ex;
    logic        m_wb_en;
    logic [4:0]  m_wb_reg;
    logic [31:0] m_wb_val;
    logic [7:0]  mref [NBYTES];

    function automatic int idx(input logic [31:0] ad);
        return int'(ad % 32'(NBYTES));
    endfunction

    function automatic logic [7:0] rdb(input logic [31:0] ad);
        return mref[idx(ad)];
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] ad);
        logic [31:0] w;
        w = ad & ~32'd3;
        return {rdb(w + 3), rdb(w + 2), rdb(w + 1), rdb(w)};
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] ad);
        logic [7:0]  by;
        logic [15:0] h;
        logic [31:0] hb;
        by = rdb(ad);
        hb = ad & ~32'd1;
        h  = {rdb(hb + 1), rdb(hb)};
        case (f3)
            3'd0:    return {{24{by[7]}}, by};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'd0, by};
            3'd5:    return {16'd0, h};
            default: return rd_word(ad);
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] d);
        logic [31:0] base;
        case (f3)
            3'd0: mref[idx(ad)] = d[7:0];
            3'd1: begin
                base = ad & ~32'd1;
                mref[idx(base)]     = d[7:0];
                mref[idx(base + 1)] = d[15:8];
            end
            3'd2: begin
                base = ad & ~32'd3;
                for (int k = 0; k < 4; k++) mref[idx(base + 32'(k))] = 8'(d >> (8 * k));
            end
            default: ;
        endcase
    endtask

    function automatic ex_t model_exec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        ex_t        e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [4:0] sh;
        opc  = ins[6:0];
        f3   = ins[14:12];
        sh   = b[4:0];
        e    = '0;
        e.rd = ins[11:7];
        e.f3 = f3;
        if (opc == C_OP || opc == C_OPIMM) begin
            e.wen = 1'b1;
            case (f3)
                3'd0: e.res = (opc == C_OP && ins[30]) ? a - b : a + b;
                3'd1: e.res = a << sh;
                3'd2: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
                3'd4: e.res = a ^ b;
                3'd5: e.res = ins[30] ? 32'($signed(a) >>> sh) : a >> sh;
                3'd6: e.res = a | b;
                default: e.res = a & b;
            endcase
        end else if (opc == C_LUI) begin
            e.res = {ins[31:12], 12'h000};
            e.wen = 1'b1;
        end else if (opc == C_LOAD) begin
            e.addr = a + b;
            e.res  = a + b;
            e.ren  = 1'b1;
            e.wen  = 1'b1;
        end else if (opc == C_STORE) begin
            e.addr = a + {{20{ins[31]}}, ins[31:25], ins[11:7]};
            e.res  = b;
            e.sen  = 1'b1;
        end else if (opc == C_BRANCH) begin
            e.res = a - b;
        end
        e.zero = (opc == C_BRANCH) ? (a == b) : (e.res == 32'd0);
        if (e.rd == 5'd0) e.wen = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        m_ex     = '0;
        m_wb_en  = 1'b0;
        m_wb_reg = '0;
        m_wb_val = '0;
`ifdef DMEM_RESET_CLEAR_EN
        for (int k = 0; k < NBYTES; k++) mref[k] = 8'h00;
`endif
    endtask

    task automatic check_state(input string p);
        chk({p, ".alu_out"},      alu_out,              m_ex.res);
        chk({p, ".zero"},         32'(zero),            32'(m_ex.zero));
        chk({p, ".alu_reg_w_en"}, 32'(alu_reg_w_en),    32'(m_ex.wen));
        chk({p, ".alu_rd"},       32'(alu_rd),          32'(m_ex.rd));
        chk({p, ".wb_en"},        32'(wb_en),           32'(m_wb_en));
        chk({p, ".wb_reg"},       32'(wb_reg),          32'(m_wb_reg));
        chk({p, ".wb_val"},       wb_val,               m_wb_val);
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input string p);
        ins_dec_out = ins;
        alu_in1     = a;
        alu_in2     = b;
        @(posedge clk);
        #1;
        m_wb_en  = m_ex.wen;
        m_wb_reg = m_ex.rd;
        m_wb_val = m_ex.ren ? model_load(m_ex.f3, m_ex.addr) : m_ex.res;
        if (m_ex.sen) model_store(m_ex.f3, m_ex.addr, m_ex.res);
        m_ex = model_exec(ins, a, b);
        check_state(p);
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] opc, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic alt);
        return {1'b0, alt, 5'd0, 5'($urandom), 5'($urandom), f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
        return {12'($urandom), 5'($urandom), f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [11:0] imm);
        return {imm[11:5], 5'($urandom), 5'($urandom), f3, imm[4:0], C_STORE};
    endfunction

    function automatic logic [31:0] enc_b();
        return {7'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), C_BRANCH};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] old;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [6:0]  junk [6];
        junk = '{7'h6F, 7'h67, 7'h17, 7'h73, 7'h0F, 7'h00};

        for (int k = 0; k < NBYTES; k++) mref[k] = 8'hxx;
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        @(negedge clk);
        rst = 1'b0;

        // Fill memory so every later load has defined data.
        for (int i = 0; i < WORDS; i++) step(enc_s(3'd2, 12'd0), 32'(i * 4), $urandom, "init");

        // ADD rd=3, 5 + 7
        step(enc_r(C_OP, 3'd0, 5'd3, 1'b0), 32'd5, 32'd7, "add");
        chk("add.alu_out", alu_out, 32'd12);
        chk("add.alu_rd", 32'(alu_rd), 32'd3);
        step(BUBBLE, 32'd0, 32'd0, "add_wb");
        chk("add.wb_en", 32'(wb_en), 32'd1);
        chk("add.wb_reg", 32'(wb_reg), 32'd3);
        chk("add.wb_val", wb_val, 32'd12);

        // Branch equality
        step(enc_b(), 32'h1234, 32'h1234, "beq");
        chk("beq.zero", 32'(zero), 32'd1);
        step(enc_b(), 32'h1234, 32'h1235, "bne");
        chk("bne.zero", 32'(zero), 32'd0);
        chk("beq.wb_en", 32'(wb_en), 32'd0);

        // Shifts and compares
        step(enc_r(C_OP, 3'd5, 5'd4, 1'b1), 32'h8000_0000, 32'd4, "sra");
        chk("sra.alu_out", alu_out, 32'hF800_0000);
        step(enc_r(C_OP, 3'd5, 5'd4, 1'b0), 32'h8000_0000, 32'd4, "srl");
        chk("srl.alu_out", alu_out, 32'h0800_0000);
        step(enc_r(C_OP, 3'd3, 5'd4, 1'b0), 32'hFFFF_FFFF, 32'd1, "sltu");
        chk("sltu.alu_out", alu_out, 32'd0);
        step(enc_r(C_OP, 3'd2, 5'd4, 1'b0), 32'hFFFF_FFFF, 32'd1, "slt");
        chk("slt.alu_out", alu_out, 32'd1);

        // SW then loads of the same word
        step(enc_s(3'd2, 12'd0), 32'h10, 32'hDEAD_BEEF, "sw");
        step(enc_i(C_LOAD, 3'd2, 5'd5), 32'h10, 32'd0, "lw");
        step(enc_i(C_LOAD, 3'd1, 5'd6), 32'h10, 32'd2, "lh");
        chk("lw.wb_val", wb_val, 32'hDEAD_BEEF);
        chk("lw.wb_reg", 32'(wb_reg), 32'd5);
        step(enc_i(C_LOAD, 3'd4, 5'd7), 32'h10, 32'd0, "lbu");
        chk("lh.wb_val", wb_val, 32'hFFFF_DEAD);
        step(BUBBLE, 32'd0, 32'd0, "lbu_wb");
        chk("lbu.wb_val", wb_val, 32'h0000_00EF);

        // SB into lane 1 of word 0x20
        old = rd_word(32'h20);
        step(enc_s(3'd0, 12'd1), 32'h20, {24'($urandom), 8'h80}, "sb");
        step(enc_i(C_LOAD, 3'd0, 5'd8), 32'h21, 32'd0, "lb");
        step(enc_i(C_LOAD, 3'd4, 5'd9), 32'h20, 32'd1, "lbu2");
        chk("lb.wb_val", wb_val, 32'hFFFF_FF80);
        step(enc_i(C_LOAD, 3'd2, 5'd10), 32'h20, 32'd0, "lw2");
        chk("lbu2.wb_val", wb_val, 32'h0000_0080);
        step(BUBBLE, 32'd0, 32'd0, "lw2_wb");
        chk("sb.other_bytes", wb_val, (old & 32'hFFFF_00FF) | 32'h0000_8000);

        // Randomized mix
        for (int n = 0; n < 400; n++) begin
            r1 = $urandom;
            r2 = $urandom;
            case ($urandom_range(0, 6))
                0: step(enc_r(C_OP, 3'($urandom), 5'($urandom), 1'($urandom)), r1, r2, "rnd_op");
                1: step(enc_i(C_OPIMM, 3'($urandom), 5'($urandom)), r1, r2, "rnd_opimm");
                2: step(enc_i(C_LUI, 3'($urandom), 5'($urandom)), r1, r2, "rnd_lui");
                3: step(enc_i(C_LOAD, 3'($urandom), 5'($urandom)), r1, r2, "rnd_load");
                4: step(enc_s(3'($urandom_range(0, 2)), 12'($urandom)), r1, r2, "rnd_store");
                5: step(enc_b(), r1, ($urandom_range(0, 1) != 0) ? r1 : r2, "rnd_branch");
                default: step({25'($urandom), junk[$urandom_range(0, 5)]}, r1, r2, "rnd_bubble");
            endcase
        end

        // Reset while a store sits in the execute register
        old = rd_word(32'h40);
        step(enc_r(C_OP, 3'd0, 5'd7, 1'b0), 32'd1, 32'd2, "pre_rst_add");
        step(enc_s(3'd2, 12'd0), 32'h40, ~old, "pre_rst_sw");
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst.wb_en", 32'(wb_en), 32'd0);
        chk("rst.alu_reg_w_en", 32'(alu_reg_w_en), 32'd0);
        check_state("rst");
        @(negedge clk);
        rst = 1'b0;
        step(enc_i(C_LOAD, 3'd2, 5'd11), 32'h40, 32'd0, "rst_lw");
        step(BUBBLE, 32'd0, 32'd0, "rst_lw_wb");
`ifdef DMEM_RESET_CLEAR_EN
        chk("rst.mem", wb_val, 32'd0);
`else
        chk("rst.mem", wb_val, old);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
